// File: rtl/can_crc_if.sv
// Bit-slot and result signals between the frame FSM / bit-stuffing layer and the CAN CRC engine.
interface can_crc_if #(
   parameter int CRC_W = 15,
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             mode;
   logic             din;
   logic             din_valid;
   logic             stuff;
   logic             busy;
   logic             tx_bit;
   logic [CRC_W-1:0] crc;
   logic             done;
   logic             crc_err;

   modport master (
      output start, len, mode, din, din_valid, stuff,
      input  busy, tx_bit, crc, done, crc_err
   );

   modport slave (
      input  start, len, mode, din, din_valid, stuff,
      output busy, tx_bit, crc, done, crc_err
   );
endinterface

// File: rtl/can_crc_engine.sv
// Serial CAN CRC engine: accumulates the CRC over the data bits, then serialises it (TX)
// or runs the received CRC field through the same register and checks for a zero residue (RX).
//
// state  | meaning
// IDLE   | waiting for start
// DATA   | accumulating CRC over len data bits
// CRC    | TX: shifting out latched CRC; RX: folding received CRC field into r
// DONE   | one-cycle done pulse, crc_err valid
module can_crc_engine #(
   parameter int               CRC_W = 15,
   parameter logic [CRC_W-1:0] POLY  = 15'h4599,
   parameter logic [CRC_W-1:0] INIT  = '0,
   parameter int               LEN_W = 8
) (
   input logic      clk,
   input logic      rst,
   can_crc_if.slave bus
);
   localparam int               CNT_W   = LEN_W + 1;
   localparam logic [CNT_W-1:0] CRC_CNT = CNT_W'(CRC_W);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

   state_t           r_state;
   logic [CRC_W-1:0] r_reg;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_len;
   logic             r_mode;
   logic             r_err;

   logic             w_accept;
   logic             w_fb;
   logic [CRC_W-1:0] w_upd;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_accept  = bus.din_valid & ~bus.stuff;
   assign w_fb      = bus.din ^ r_reg[CRC_W-1];
   assign w_upd     = {r_reg[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_reg   <= INIT;
         r_crc   <= '0;
         r_shift <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_mode  <= 1'b0;
         r_err   <= 1'b0;
      end else if (bus.start) begin
         // start wins in every state, so an in-flight frame is dropped without done
         r_reg  <= INIT;
         r_cnt  <= '0;
         r_len  <= bus.len;
         r_mode <= bus.mode;
         r_err  <= 1'b0;
         if (bus.len == '0) begin
            r_state <= S_CRC;
            r_crc   <= INIT;
            r_shift <= INIT;
         end else begin
            r_state <= S_DATA;
         end
      end else begin
         case (r_state)
            S_DATA: begin
               if (w_accept) begin
                  r_reg <= w_upd;
                  if (w_cnt_inc == {1'b0, r_len}) begin
                     r_state <= S_CRC;
                     r_crc   <= w_upd;
                     r_shift <= w_upd;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
            end
            S_CRC: begin
               if (w_accept) begin
                  r_cnt <= w_cnt_inc;
                  if (r_mode) r_reg   <= w_upd;
                  else        r_shift <= {r_shift[CRC_W-2:0], 1'b0};
                  if (w_cnt_inc == CRC_CNT) begin
                     r_state <= S_DONE;
                     r_err   <= r_mode & (w_upd != '0);
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = (r_state == S_DATA) || (r_state == S_CRC);
   assign bus.done    = (r_state == S_DONE);
   assign bus.tx_bit  = (r_state == S_CRC) && !r_mode && r_shift[CRC_W-1];
   assign bus.crc     = r_crc;
   assign bus.crc_err = r_err;
endmodule

// File: tb/tb_can_crc_engine.sv
// Directed bench for can_crc_engine: table of frames plus stuff/abort/reset sequences.
module tb_can_crc_engine;
   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;
   int   done_seen = 0;

   can_crc_if #(.CRC_W(15), .LEN_W(8)) bus ();

   can_crc_engine #(.CRC_W(15), .POLY(15'h4599), .INIT(15'h0000), .LEN_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done) done_seen++;

   typedef struct {
      logic        mode;
      int          len;
      logic [15:0] data;
      logic [14:0] rx;
      logic [14:0] exp_crc;
      logic        exp_err;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.len = '0; bus.mode = 1'b0;
      bus.din = 1'b0; bus.din_valid = 1'b0; bus.stuff = 1'b0;
   endtask

   initial begin
      int          d0;
      logic [14:0] cap;
      int          waited;

      vecs[0]  = '{1'b0, 1, 16'b1,   15'h0000, 15'h4599, 1'b0};
      vecs[1]  = '{1'b0, 2, 16'b10,  15'h0000, 15'h4EAB, 1'b0};
      vecs[2]  = '{1'b0, 2, 16'b01,  15'h0000, 15'h4599, 1'b0};
      vecs[3]  = '{1'b0, 3, 16'b101, 15'h0000, 15'h1D56, 1'b0};
      vecs[4]  = '{1'b0, 0, 16'b0,   15'h0000, 15'h0000, 1'b0};
      vecs[5]  = '{1'b1, 1, 16'b1,   15'h4599, 15'h4599, 1'b0};
      vecs[6]  = '{1'b1, 1, 16'b1,   15'h4598, 15'h4599, 1'b1};
      vecs[7]  = '{1'b1, 2, 16'b10,  15'h4EAB, 15'h4EAB, 1'b0};
      vecs[8]  = '{1'b1, 3, 16'b101, 15'h1D56, 15'h1D56, 1'b0};
      vecs[9]  = '{1'b1, 2, 16'b10,  15'h4599, 15'h4EAB, 1'b1};
      vecs[10] = '{1'b1, 0, 16'b0,   15'h0000, 15'h0000, 1'b0};

      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      chk("rst_busy",   32'(bus.busy),    32'd0);
      chk("rst_crc",    32'(bus.crc),     32'd0);
      chk("rst_done",   32'(bus.done),    32'd0);
      chk("rst_err",    32'(bus.crc_err), 32'd0);
      chk("rst_tx_bit", 32'(bus.tx_bit),  32'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 11; v++) begin
         d0 = done_seen;
         bus.start = 1'b1; bus.len = 8'(vecs[v].len); bus.mode = vecs[v].mode;
         tick();
         bus.start = 1'b0;
         chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd1);
         for (int i = 0; i < vecs[v].len; i++) begin
            bus.din = vecs[v].data[vecs[v].len-1-i]; bus.din_valid = 1'b1;
            tick();
         end
         chk($sformatf("v%0d_crc", v), 32'(bus.crc), 32'(vecs[v].exp_crc));
         cap = '0;
         for (int i = 0; i < 15; i++) begin
            cap[14-i] = bus.tx_bit;
            bus.din = vecs[v].mode ? vecs[v].rx[14-i] : 1'b0;
            bus.din_valid = 1'b1;
            tick();
         end
         bus.din_valid = 1'b0;
         chk($sformatf("v%0d_txseq", v), 32'(cap),
             vecs[v].mode ? 32'd0 : 32'(vecs[v].exp_crc));
         chk($sformatf("v%0d_done", v), 32'(bus.done), 32'd1);
         chk($sformatf("v%0d_no_early_done", v), 32'(done_seen - d0), 32'd0);
         chk($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'd0);
         chk($sformatf("v%0d_err", v), 32'(bus.crc_err), 32'(vecs[v].exp_err));
         tick();
         chk($sformatf("v%0d_done_pulse", v), 32'(bus.done), 32'd0);
         chk($sformatf("v%0d_err_held", v), 32'(bus.crc_err), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_done_count", v), 32'(done_seen - d0), 32'd1);
      end

      // stuff bit and idle gaps: 4 extra cycles over len+16
      d0 = done_seen;
      bus.start = 1'b1; bus.len = 8'd2; bus.mode = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.din = 1'b1; bus.din_valid = 1'b1; tick();
      bus.din_valid = 1'b0; tick(); tick();
      bus.din = 1'b1; bus.din_valid = 1'b1; bus.stuff = 1'b1; tick();
      bus.stuff = 1'b0; bus.din = 1'b0; tick();
      chk("stuff_crc", 32'(bus.crc), 32'h4EAB);
      cap = '0;
      for (int i = 0; i < 15; i++) begin
         if (i == 7) begin
            bus.din_valid = 1'b0; tick();
         end
         cap[14-i] = bus.tx_bit;
         bus.din = 1'b0; bus.din_valid = 1'b1; tick();
      end
      bus.din_valid = 1'b0;
      chk("stuff_txseq", 32'(cap), 32'h4EAB);
      chk("stuff_done_at_22", 32'(bus.done), 32'd1);
      chk("stuff_no_early_done", 32'(done_seen - d0), 32'd0);
      tick();

      // abort mid-DATA, restart slot with din_valid is not consumed
      d0 = done_seen;
      bus.start = 1'b1; bus.len = 8'd3; bus.mode = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.din = 1'b1; bus.din_valid = 1'b1; tick();
      bus.start = 1'b1; bus.len = 8'd2; bus.mode = 1'b0; bus.din = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.din = 1'b1; tick();
      bus.din = 1'b0; tick();
      chk("abort_crc", 32'(bus.crc), 32'h4EAB);
      chk("abort_tx_mode", 32'(bus.tx_bit), 32'd1);
      waited = 0;
      while (!bus.done && waited < 30) begin
         bus.din = 1'b0; bus.din_valid = 1'b1; tick();
         waited++;
      end
      bus.din_valid = 1'b0;
      chk("abort_done_slots", 32'(waited), 32'd15);
      tick();
      chk("abort_done_count", 32'(done_seen - d0), 32'd1);

      // reset mid-CRC
      d0 = done_seen;
      bus.start = 1'b1; bus.len = 8'd1; bus.mode = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.din = 1'b1; bus.din_valid = 1'b1; tick();
      bus.din_valid = 1'b0;
      chk("pre_rst_tx_bit", 32'(bus.tx_bit), 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst_busy",   32'(bus.busy),    32'd0);
      chk("midrst_crc",    32'(bus.crc),     32'd0);
      chk("midrst_tx_bit", 32'(bus.tx_bit),  32'd0);
      chk("midrst_done",   32'(bus.done),    32'd0);
      chk("midrst_err",    32'(bus.crc_err), 32'd0);
      rst = 1'b0;
      bus.din_valid = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      bus.din_valid = 1'b0;
      chk("midrst_stays_idle", 32'(bus.busy), 32'd0);
      chk("midrst_no_done", 32'(done_seen - d0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
